sram_like_responder: RTL and testbench

//   Slave end of the SRAM-like instruction/data bus driven by the fetch (and later LSU) stage.

---
 rtl/sram_resp_pkg.sv | 26 ++
 rtl/sram_like_responder_resp_queue.sv | 76 +++++++
 rtl/sram_like_responder.sv | 97 +++++++++
 tb/tb_sram_like_responder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SRAM-like bus responder.
// Optional random stall: SRAM_RESP_RAND_STALL_EN.
package sram_resp_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        is_wr;
    logic [31:0] data;
    logic [3:0]  cnt;
  } resp_entry_t;

  // Galois form of x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return s[0] ? ((s >> 1) ^ LFSR_TAPS)
                : (s >> 1);
  endfunction

endpackage

// File: rtl/sram_like_responder_resp_queue.sv
// In-order response FIFO; every valid entry counts down
// to zero and the head is released once it reaches zero.
module resp_queue
  import sram_resp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  resp_entry_t                  push_entry_i,
  input  logic                         pop_i,
  output logic                         head_due_o,
  output logic                         head_is_wr_o,
  output logic [31:0]                  head_data_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t      mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    rd_q;
  logic [PW-1:0]    wr_q;
  logic [CW-1:0]    cnt_q;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0
                                 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && mem_q[i].cnt != 4'd0)
        mem_q[i].cnt <= mem_q[i].cnt - 4'd1;
    end
    if (push_i)
      mem_q[wr_q] <= push_entry_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (pop_i) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= nxt(rd_q);
      end
      // push after pop so a full-queue swap keeps the slot valid
      if (push_i) begin
        vld_q[wr_q] <= 1'b1;
        wr_q        <= nxt(wr_q);
      end
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_due_o   = vld_q[rd_q]
                     && (mem_q[rd_q].cnt == 4'd0);
  assign head_is_wr_o = mem_q[rd_q].is_wr;
  assign head_data_o  = mem_q[rd_q].data;
  assign full_o       = (cnt_q == CW'(DEPTH));
  assign count_o      = cnt_q;

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like bus slave: byte-strobed RAM, fixed-latency in-order replies.
// Define SRAM_RESP_RAND_STALL_EN for pseudo-random addr_ok stalls.
module sram_like_responder
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]       ram_q [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              stall;
  logic              full;
  logic              head_due;
  logic              head_is_wr;
  logic [31:0]       head_data;
  logic [CW-1:0]     unused_count;
  logic              unused_bits;
  resp_entry_t       push_entry;

  assign idx = addr[ADDR_W+1:2];

`ifdef SRAM_RESP_RAND_STALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // head_due lets a full queue swap its head for a new entry
  assign addr_ok = !reset && !stall
                && (!full || head_due);
  assign accept  = req && addr_ok;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept && wr && wstrb[i])
        ram_q[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.is_wr = wr;
    push_entry.data  = wr ? 32'd0 : ram_q[idx];
    push_entry.cnt   = 4'(LATENCY - 1);
  end

  resp_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .pop_i        (data_ok),
    .head_due_o   (head_due),
    .head_is_wr_o (head_is_wr),
    .head_data_o  (head_data),
    .full_o       (full),
    .count_o      (unused_count)
  );

  assign data_ok = head_due && !reset;
  assign rdata   = (data_ok && !head_is_wr)
                 ? head_data : 32'd0;

  // size is informational; upper address bits alias
  assign unused_bits = ^{size, addr[31:ADDR_W+2],
                         addr[1:0]};

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench: three responder configs driven from one bus,
// checked every cycle against a cycle-based scoreboard.
module tb_sram_like_responder;

  localparam int AW = 10;

  typedef struct {
    bit          is_wr;
    logic [31:0] data;
    bit          known;
    int          due;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_v = '0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [3:0]  wstrb = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  aok;
  logic [2:0]  dok;
  logic [31:0] rd [3];

  exp_t        sbq [3][$];
  logic [31:0] mem [3][1024];
  bit   [3:0]  kn  [3][1024];
  bit          last_acc [3];
  bit          last_aok [3];
  bit          ov_use = 1'b0;
  logic [31:0] ov_data = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          elig = 0;
  int          stalls = 0;

  always #5 clk = ~clk;

  sram_like_responder #(
    .ADDR_W(AW), .LATENCY(1), .DEPTH(2)
  ) u_a (
    .clk(clk), .reset(reset), .req(req_v[0]),
    .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata),
    .addr_ok(aok[0]), .data_ok(dok[0]),
    .rdata(rd[0])
  );

  sram_like_responder #(
    .ADDR_W(AW), .LATENCY(3), .DEPTH(2)
  ) u_b (
    .clk(clk), .reset(reset), .req(req_v[1]),
    .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata),
    .addr_ok(aok[1]), .data_ok(dok[1]),
    .rdata(rd[1])
  );

  sram_like_responder #(
    .ADDR_W(AW), .LATENCY(1), .DEPTH(1)
  ) u_c (
    .clk(clk), .reset(reset), .req(req_v[2]),
    .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata),
    .addr_ok(aok[2]), .data_ok(dok[2]),
    .rdata(rd[2])
  );

  function automatic int latf(int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic int depthf(int k);
    return (k == 2) ? 1 : 2;
  endfunction

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      int   n;
      int   ix;
      bit   due;
      bit   eok;
      bit   acc;
      exp_t e;
      n   = sbq[k].size();
      due = !reset && n > 0 && sbq[k][0].due == cyc;
      eok = !reset && (n < depthf(k) || due);
`ifdef SRAM_RESP_RAND_STALL_EN
      chk($sformatf("addr_ok_cap%0d", k),
          32'(aok[k] & ~eok), 32'd0);
      if (k == 0 && eok) begin
        elig++;
        if (!aok[k]) stalls++;
      end
      acc = req_v[k] && aok[k] && !reset;
`else
      chk($sformatf("addr_ok%0d", k),
          32'(aok[k]), 32'(eok));
      acc = req_v[k] && eok;
`endif
      chk($sformatf("data_ok%0d", k),
          32'(dok[k]), 32'(due));
      if (due) begin
        e = sbq[k].pop_front();
        if (e.known)
          chk($sformatf("rdata%0d", k), rd[k], e.data);
      end
      if (reset) begin
        chk($sformatf("rst_rdata%0d", k), rd[k], 32'd0);
        sbq[k].delete();
      end
      last_acc[k] = acc;
      last_aok[k] = aok[k];
      if (acc) begin
        ix = int'(addr[AW+1:2]);
        e.is_wr = wr;
        e.due   = cyc + latf(k);
        e.known = 1'b1;
        if (wr) begin
          e.data = 32'd0;
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
              mem[k][ix][8*b +: 8] = wdata[8*b +: 8];
              kn[k][ix][b] = 1'b1;
            end
          end
        end else begin
          e.data  = mem[k][ix];
          e.known = &kn[k][ix];
        end
        if (ov_use) begin
          e.data  = ov_data;
          e.known = 1'b1;
        end
        sbq[k].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(int k, bit w, logic [3:0] s,
                       logic [31:0] a, logic [31:0] d,
                       bit use_e, logic [31:0] ex);
    int n;
    n = 0;
    wr = w; wstrb = s; addr = a; wdata = d;
    req_v = '0;
    req_v[k] = 1'b1;
    ov_use = use_e;
    ov_data = ex;
    do begin
      step();
      n++;
    end while (!last_acc[k] && n < 50);
    chk($sformatf("accept_timeout%0d", k),
        32'(last_acc[k]), 32'd1);
    req_v = '0;
    ov_use = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_v = '0;
    while ((sbq[0].size() + sbq[1].size()
            + sbq[2].size()) > 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(sbq[0].size()
        + sbq[1].size() + sbq[2].size()), 32'd0);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [14];
    bit   pat_exp [10];
    bit   pat [10];
    int   nacc;

    tbl[0]  = '{1, 4'hF, 32'h1c000000, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{0, 4'h0, 32'h1c000000, 32'h0, 32'hDEADBEEF};
    tbl[2]  = '{1, 4'hF, 32'h1c000010, 32'h11223344, 32'h0};
    tbl[3]  = '{1, 4'h2, 32'h1c000010, 32'h0000AB00, 32'h0};
    tbl[4]  = '{0, 4'hF, 32'h1c000010, 32'h0, 32'h1122AB44};
    tbl[5]  = '{1, 4'h0, 32'h1c000010, 32'hFFFFFFFF, 32'h0};
    tbl[6]  = '{0, 4'h0, 32'h1c000010, 32'h0, 32'h1122AB44};
    tbl[7]  = '{1, 4'hF, 32'h00000014, 32'h0, 32'h0};
    tbl[8]  = '{1, 4'h9, 32'h00000014, 32'hA5A5A5A5, 32'h0};
    tbl[9]  = '{0, 4'h0, 32'h00000014, 32'h0, 32'hA50000A5};
    tbl[10] = '{0, 4'h0, 32'h00001000, 32'h0, 32'hDEADBEEF};
    tbl[11] = '{1, 4'h1, 32'h1c000011, 32'h000000CD, 32'h0};
    tbl[12] = '{0, 4'h0, 32'h1c000010, 32'h0, 32'h1122ABCD};
    tbl[13] = '{0, 4'h0, 32'hFFC00000, 32'h0, 32'hDEADBEEF};

    pat_exp = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1};

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 14; i++)
      issue(0, tbl[i].wr, tbl[i].strb, tbl[i].addr,
            tbl[i].wdata, 1'b1, tbl[i].exp);
    drain();

    for (int i = 0; i < 10; i++)
      issue(1, 1'b1, 4'hF, 32'(i * 4),
            32'hB0000000 + 32'(i), 1'b0, 32'h0);
    drain();
    req_v = 3'b010;
    wr = 1'b0;
    addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      pat[i] = last_aok[1];
      if (last_acc[1]) addr = addr + 32'd4;
    end
    drain();
`ifndef SRAM_RESP_RAND_STALL_EN
    for (int i = 0; i < 10; i++)
      chk($sformatf("l3d2_pattern[%0d]", i),
          32'(pat[i]), 32'(pat_exp[i]));
`endif

    for (int i = 0; i < 3; i++)
      issue(2, 1'b1, 4'hF, 32'(i * 4),
            32'hC0C0C000 + 32'(i), 1'b0, 32'h0);
    drain();
    req_v = 3'b100;
    wr = 1'b0;
    nacc = 0;
    for (int i = 0; i < 3; i++) begin
      addr = 32'(i * 4);
      step();
      if (last_acc[2]) nacc++;
    end
    drain();
`ifndef SRAM_RESP_RAND_STALL_EN
    chk("l1d1_b2b_accepts", 32'(nacc), 32'd3);
`endif

    req_v = 3'b010;
    wr = 1'b0;
    addr = 32'h4;
    step();
    step();
    req_v = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_v = 3'b010;
    addr = 32'h8;
    step();
    chk("post_reset_accept", 32'(last_acc[1]), 32'd1);
    req_v = '0;
    drain();

    for (int i = 0; i < 16; i++) begin
      issue(0, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0, 0);
      issue(1, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0, 0);
    end
    drain();
    elig = 0;
    stalls = 0;
    for (int i = 0; i < 1000; i++) begin
      int k;
      k = (i % 3 == 0) ? 1 : 0;
      issue(k, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            {20'($urandom), 6'($urandom_range(0, 15)),
             2'($urandom)}
              & 32'hFFFF_F03F,
            $urandom, 1'b0, 0);
    end
    drain();
`ifdef SRAM_RESP_RAND_STALL_EN
    chk("stall_rate_ge20", 32'(stalls * 100 >= elig * 20),
        32'd1);
    chk("stall_rate_le30", 32'(stalls * 100 <= elig * 30),
        32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
